// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with sync, blank and line/frame strobes.
// Latency: vga_x/vga_y/pulses are registered; hs/vs/blank lag the counters by PIPE_DLY enabled cycles.
// Backpressure: none; en low freezes counters, frame count and delay pipeline.
module vga_timing_gen #(
    parameter int H_VISIBLE = 1024,
    parameter int H_FRONT   = 24,
    parameter int H_SYNC    = 136,
    parameter int H_BACK    = 160,
    parameter int V_VISIBLE = 768,
    parameter int V_FRONT   = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BACK    = 29,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int CNT_W     = 12,
    parameter int PIPE_DLY  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] vga_x,
    output logic [CNT_W-1:0] vga_y,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_blank,
    output logic             vga_clk,
    output logic             line_start,
    output logic             frame_start,
    output logic [15:0]      frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic hs_lvl;
    logic vs_lvl;
    logic blank_raw;

    assign vga_clk = clk;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vga_x       <= '0;
            vga_y       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (en) begin
                if (vga_x == H_LAST) begin
                    vga_x      <= '0;
                    line_start <= 1'b1;
                    if (vga_y == V_LAST) begin
                        vga_y       <= '0;
                        frame_start <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                    end else begin
                        vga_y <= vga_y + CNT_W'(1);
                    end
                end else begin
                    vga_x <= vga_x + CNT_W'(1);
                end
            end
        end
    end

    // Polarity is folded in here so the delay line carries final output levels.
    // vs only depends on vga_y, so it naturally switches at the start of a line.
    assign hs_lvl    = ((vga_x >= HS_START) && (vga_x < HS_END)) ? HS_POL : ~HS_POL;
    assign vs_lvl    = ((vga_y >= VS_START) && (vga_y < VS_END)) ? VS_POL : ~VS_POL;
    assign blank_raw = (vga_x < H_VIS) && (vga_y < V_VIS);

    generate
        if (PIPE_DLY == 0) begin : g_comb
            assign vga_hs    = hs_lvl;
            assign vga_vs    = vs_lvl;
            assign vga_blank = blank_raw;
        end else begin : g_pipe
            logic [PIPE_DLY-1:0] hs_sr;
            logic [PIPE_DLY-1:0] vs_sr;
            logic [PIPE_DLY-1:0] bl_sr;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    hs_sr <= {PIPE_DLY{~HS_POL}};
                    vs_sr <= {PIPE_DLY{~VS_POL}};
                    bl_sr <= '0;
                end else if (en) begin
                    hs_sr <= (hs_sr << 1) | PIPE_DLY'(hs_lvl);
                    vs_sr <= (vs_sr << 1) | PIPE_DLY'(vs_lvl);
                    bl_sr <= (bl_sr << 1) | PIPE_DLY'(blank_raw);
                end
            end

            assign vga_hs    = hs_sr[PIPE_DLY-1];
            assign vga_vs    = vs_sr[PIPE_DLY-1];
            assign vga_blank = bl_sr[PIPE_DLY-1];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default timing, tiny active-high combinational,
// tiny delayed) driven cycle by cycle; expectations are queued and checked by a separate monitor.
module tb_vga_timing_gen;

    typedef struct {
        int hv, hf, hs, hb;
        int vv, vf, vs, vb;
        bit hp, vp;
        int d;
    } tcfg_t;

    typedef struct {
        int c;
        int i;
        int s;
        int v;
    } exp_t;

    logic        clk;
    logic        rst_i [3];
    logic        en_i  [3];
    logic [11:0] xo    [3];
    logic [11:0] yo    [3];
    logic        hso   [3];
    logic        vso   [3];
    logic        blo   [3];
    logic        vco   [3];
    logic        lso   [3];
    logic        fso   [3];
    logic [15:0] fco   [3];

    tcfg_t cfg [3];
    int    e   [3];
    exp_t  q   [$];
    int    cyc    = 0;
    int    checks = 0;
    int    errors = 0;
    logic  mon_kick = 1'b0;

    vga_timing_gen u_a (
        .clk(clk), .reset(rst_i[0]), .en(en_i[0]),
        .vga_x(xo[0]), .vga_y(yo[0]), .vga_hs(hso[0]), .vga_vs(vso[0]),
        .vga_blank(blo[0]), .vga_clk(vco[0]), .line_start(lso[0]),
        .frame_start(fso[0]), .frame_count(fco[0])
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(0)
    ) u_b (
        .clk(clk), .reset(rst_i[1]), .en(en_i[1]),
        .vga_x(xo[1]), .vga_y(yo[1]), .vga_hs(hso[1]), .vga_vs(vso[1]),
        .vga_blank(blo[1]), .vga_clk(vco[1]), .line_start(lso[1]),
        .frame_start(fso[1]), .frame_count(fco[1])
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(3)
    ) u_c (
        .clk(clk), .reset(rst_i[2]), .en(en_i[2]),
        .vga_x(xo[2]), .vga_y(yo[2]), .vga_hs(hso[2]), .vga_vs(vso[2]),
        .vga_blank(blo[2]), .vga_clk(vco[2]), .line_start(lso[2]),
        .frame_start(fso[2]), .frame_count(fco[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sig_name(int s);
        case (s)
            0: return "vga_x";
            1: return "vga_y";
            2: return "vga_hs";
            3: return "vga_vs";
            4: return "vga_blank";
            5: return "line_start";
            6: return "frame_start";
            7: return "frame_count";
            default: return "vga_clk";
        endcase
    endfunction

    function automatic int actual(int i, int s);
        case (s)
            0: return int'(xo[i]);
            1: return int'(yo[i]);
            2: return int'(hso[i]);
            3: return int'(vso[i]);
            4: return int'(blo[i]);
            5: return int'(lso[i]);
            6: return int'(fso[i]);
            7: return int'(fco[i]);
            default: return int'(vco[i]);
        endcase
    endfunction

    // Expected outputs after 'en_cnt' enabled edges since reset; 'pulse' = last edge was enabled.
    function automatic int model(int i, int s, int en_cnt, bit pulse);
        tcfg_t c;
        int    ht, vt, x, y, p, px, py;
        bit    hw, vw, bv;
        c  = cfg[i];
        ht = c.hv + c.hf + c.hs + c.hb;
        vt = c.vv + c.vf + c.vs + c.vb;
        x  = en_cnt % ht;
        y  = (en_cnt / ht) % vt;
        p  = en_cnt - c.d;
        hw = 1'b0;
        vw = 1'b0;
        bv = 1'b0;
        if (p >= 0) begin
            px = p % ht;
            py = (p / ht) % vt;
            hw = (px >= c.hv + c.hf) && (px < c.hv + c.hf + c.hs);
            vw = (py >= c.vv + c.vf) && (py < c.vv + c.vf + c.vs);
            bv = (px < c.hv) && (py < c.vv);
        end
        case (s)
            0: return x;
            1: return y;
            2: return int'(hw ? c.hp : !c.hp);
            3: return int'(vw ? c.vp : !c.vp);
            4: return int'(bv);
            5: return int'(pulse && x == 0);
            6: return int'(pulse && x == 0 && y == 0);
            7: return (en_cnt / (ht * vt)) % 65536;
            default: return 0;
        endcase
    endfunction

    task automatic push_inst(input int i, input int at, input bit pulse);
        for (int s = 0; s < 9; s++) begin
            exp_t t;
            t.c = at;
            t.i = i;
            t.s = s;
            t.v = model(i, s, e[i], pulse);
            q.push_back(t);
        end
    endtask

    always @(negedge clk or posedge mon_kick) begin
        while (q.size() > 0 && q[0].c <= cyc) begin
            exp_t t;
            int   act;
            t   = q.pop_front();
            act = actual(t.i, t.s);
            checks++;
            if (t.c != cyc || act != t.v) begin
                errors++;
                $display("FAIL %s[dut%0d]: got %0d expected %0d (cycle %0d, sampled %0d)",
                         sig_name(t.s), t.i, act, t.v, t.c, cyc);
            end
        end
    end

    initial begin
        int  b_hold;
        bit  b_done;
        bit  pulse;
        int  wait_cnt;
        cfg[0] = '{1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, 1'b0, 2};
        cfg[1] = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 0};
        cfg[2] = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b0, 1'b0, 3};
        b_hold = 0;
        b_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rst_i[i] = 1'b0;
            en_i[i]  = 1'b1;
            e[i]     = 0;
        end
        repeat (2) @(negedge clk);

        checks++;
        if (xo[0] !== 12'd0 || yo[0] !== 12'd0 || hso[0] !== 1'b1 || vso[0] !== 1'b1 ||
            blo[0] !== 1'b0 || fco[0] !== 16'd0 || lso[0] !== 1'b0 || fso[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset state dut0: x=%0d y=%0d hs=%0b vs=%0b blank=%0b fc=%0d ls=%0b fs=%0b",
                     xo[0], yo[0], hso[0], vso[0], blo[0], fco[0], lso[0], fso[0]);
        end

        for (int k = 0; k < 8100; k++) begin
            @(negedge clk);
            if (k == 2) begin
                rst_i[0] = 1'b1;
                rst_i[1] = 1'b1;
                rst_i[2] = 1'b1;
            end else if (b_hold > 0) begin
                b_hold--;
                if (b_hold == 0) rst_i[1] = 1'b1;
            end
            en_i[0] = (k < 2700) ? 1'b1 : (k % 2 == 1);
            en_i[1] = 1'b1;
            en_i[2] = (k % 3 != 0);

            // Async reset of the tiny instance at x=5, y=3 in its third frame, checked mid-cycle.
            if (!b_done && rst_i[1] && e[1] == 2 * 98 + 47) begin
                #2 rst_i[1] = 1'b0;
                e[1] = 0;
                push_inst(1, cyc, 1'b0);
                #1 mon_kick = 1'b1;
                #1 mon_kick = 1'b0;
                b_done = 1'b1;
                b_hold = 3;
            end

            for (int i = 0; i < 3; i++) begin
                pulse = rst_i[i] && en_i[i];
                if (!rst_i[i])   e[i] = 0;
                else if (en_i[i]) e[i] = e[i] + 1;
                push_inst(i, cyc + 1, pulse);
            end
        end

        repeat (2) @(negedge clk);

        wait_cnt = 0;
        while (fso[1] !== 1'b1 && wait_cnt < 300) begin
            @(negedge clk);
            wait_cnt++;
        end
        checks++;
        if (fso[1] !== 1'b1) begin
            errors++;
            $display("FAIL timeout: frame_start[dut1] not seen within %0d cycles", wait_cnt);
        end

        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA/SVGA raster timing generator; successor to the fixed 1024x768 display port. Produces pixel coordinates plus sync/blank strobes, with timing, sync polarity and output alignment delay all set by parameters. Adds a pixel-enable input, line/frame start pulses and a frame counter. Sits between the pixel clock domain and the frame renderer/DAC.

Parameters:
H_VISIBLE, 1024, active pixels per line
H_FRONT, 24, horizontal front porch (pixels)
H_SYNC, 136, horizontal sync width (pixels)
H_BACK, 160, horizontal back porch (pixels)
V_VISIBLE, 768, active lines per frame
V_FRONT, 3, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BACK, 29, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)
CNT_W, 12, width of vga_x/vga_y; must hold H_TOTAL-1 and V_TOTAL-1
PIPE_DLY, 2, cycles of delay on hs/vs/blank relative to vga_x/vga_y (0..4)

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous active-low reset
en  in  1  pixel enable; counters and delay pipeline advance only when high
vga_x  out  CNT_W  horizontal counter, undelayed
vga_y  out  CNT_W  vertical counter, undelayed
vga_hs  out  1  horizontal sync, delayed PIPE_DLY enabled cycles
vga_vs  out  1  vertical sync, delayed PIPE_DLY enabled cycles
vga_blank  out  1  high = visible region, delayed PIPE_DLY enabled cycles
vga_clk  out  1  combinational copy of clk
line_start  out  1  one-cycle pulse when vga_x becomes 0
frame_start  out  1  one-cycle pulse when vga_x and vga_y both become 0
frame_count  out  16  completed frames, wraps at 65535->0

Behaviour:
- Derived: H_TOTAL = sum of H_* (1344 default); V_TOTAL = sum of V_* (806 default).
- Reset (async, reset=0): vga_x=0, vga_y=0, frame_count=0, line_start=0, frame_start=0. Delay pipeline cleared: vga_hs=~HS_POL, vga_vs=~VS_POL, vga_blank=0.
- First enabled edge after reset release: vga_x 0->1. The reset state counts as pixel (0,0); no start pulse is emitted for it.
- When en=1 at a clock edge:
  - vga_x increments.
  - At vga_x==H_TOTAL-1: vga_x->0, vga_y increments, line_start=1 for one cycle.
  - At vga_y==V_TOTAL-1 on that same line wrap: vga_y->0, frame_start=1 (line_start also 1), frame_count increments.
  - vga_x never reaches H_TOTAL; vga_y never reaches V_TOTAL.
- When en=0: counters, frame_count and delay pipeline hold; line_start/frame_start are 0.
- Raw strobes are computed from the current counters:
  - hs_raw active for H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC.
  - vs_raw active for V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC.
  - blank_raw = (x<H_VISIBLE) && (y<V_VISIBLE).
- Each raw strobe passes through a PIPE_DLY-stage shift register that advances only on enabled cycles. PIPE_DLY=0 means purely combinational outputs.
- Polarity is applied before the delay: the output equals the active level while in the sync window, the inverse otherwise.
- vsync changes aligned with vga_x=0 (start of line), not mid-line.
- Reset mid-frame: all state returns to reset values immediately, asynchronously. No partial pulses are emitted afterwards.

Test Plan:
- Reset, defaults, en=1: vga_x=0, vga_y=0, vga_hs=1, vga_vs=1, vga_blank=0, frame_count=0. After 1 enabled edge: vga_x=1.
- Run 1344 enabled cycles: vga_x wraps 1343->0, vga_y=1, line_start high exactly 1 cycle, frame_start stays 0.
- Full frame of 1344*806 cycles: vga_y wraps 805->0, frame_start and line_start both pulse, frame_count=1. vga_vs low for exactly 6*1344 cycles, starting 2 cycles after vga_y=771, x=0.
- Within one line, PIPE_DLY=2: vga_hs low for x 1050..1185 observed, i.e. 136 cycles. vga_blank high for the 1024 cycles starting when x=2 is observed.
- Toggle en 0/1 alternately: counters advance every second cycle; hs width measured in enabled cycles is still 136; no pulses during en=0.
- HS_POL=1, VS_POL=1, PIPE_DLY=0, small timing (8/2/2/2, 4/1/1/1): exact combinational waveform check. Assert reset at x=5, y=3: outputs return to reset values within the same cycle.
